// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the fetch stage
// (instruction reads) and the mem stage (data loads/stores). Data has fixed
// priority. Each transaction runs IDLE -> BUS_x -> RESP -> IDLE. Every output
// is registered, and the requester's ready pulses for exactly one cycle.
module mem_bus_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            inst_ready,
  input  logic            data_req,
  input  logic            data_we,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  input  logic [DW/8-1:0] data_wstrb,
  output logic [DW-1:0]   data_rdata,
  output logic            data_ready,
  output logic            bus_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  output logic [DW/8-1:0] bus_wstrb,
  input  logic            bus_ack,
  input  logic [DW-1:0]   bus_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUS_D = 2'd1;
  localparam logic [1:0] BUS_I = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int unsigned  CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The counter holds the number of bus cycles already spent. The abort
  // therefore fires in the TIMEOUT-th bus cycle, which gives the same response
  // timing as an ack arriving in that cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DW/8-1:0] bus_wstrb_q, bus_wstrb_d;
  logic            inst_ready_q, inst_ready_d;
  logic            data_ready_q, data_ready_d;
  logic            bus_err_q, bus_err_d;
  logic [DW-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DW-1:0]   data_rdata_q, data_rdata_d;

  logic            finish;

  // Next-state logic for the arbitration FSM, the bus outputs and the responses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    bus_err_d    = 1'b0;
    inst_rdata_d = '0;
    data_rdata_d = '0;
    finish       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (data_req) begin
          state_d     = BUS_D;
          bus_req_d   = 1'b1;
          bus_we_d    = data_we;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
          bus_wstrb_d = data_we ? data_wstrb : '0;
        end else if (inst_req) begin
          state_d     = BUS_I;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = inst_addr;
          bus_wdata_d = '0;
          bus_wstrb_d = '0;
        end
      end

      BUS_D, BUS_I: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_ack) begin
          finish = 1'b1;
          if (state_q == BUS_D) begin
            data_rdata_d = bus_we_q ? '0 : bus_rdata;
          end else begin
            inst_rdata_d = bus_rdata;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          finish    = 1'b1;
          bus_err_d = 1'b1;
        end
        if (finish) begin
          state_d      = RESP;
          bus_req_d    = 1'b0;
          bus_we_d     = 1'b0;
          bus_addr_d   = '0;
          bus_wdata_d  = '0;
          bus_wstrb_d  = '0;
          data_ready_d = (state_q == BUS_D);
          inst_ready_d = (state_q == BUS_I);
        end
      end

      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; an asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      bus_err_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
      bus_err_q    <= bus_err_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign inst_ready = inst_ready_q;
  assign data_ready = data_ready_q;
  assign bus_err    = bus_err_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

endmodule
